// File: rtl/detector_pkg.sv
// Shared detector definitions: row count, event record layout, row FSM states.
package detector_pkg;

  localparam int PixelHeight = 5;
  localparam int RowW        = $clog2(PixelHeight);
  localparam int TsWidth     = 16;

  // Per-row qualifier states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_ACTIVE,
    ST_RELEASING
  } row_state_t;

  // Event record as stored in the FIFO, MSB first: row, onset, timestamp
  typedef struct packed {
    logic [RowW-1:0]    row;
    logic               onset;
    logic [TsWidth-1:0] ts;
  } edge_event_t;

endpackage

// File: rtl/edge_event_fifo.sv
// Show-ahead synchronous FIFO for packed event records.
// The caller never pushes when full without a same-cycle pop, and never pops when empty.
module edge_event_fifo
  import detector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(edge_event_t)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;

  // Extra pointer bit distinguishes full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Pointer advance and storage write
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  // Storage is reset so the head reads zero out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/edge_event_reporter.sv
// Qualifies per-row edge flags with a run-length filter, timestamps confirmed
// onset/release transitions, and streams them out through an event FIFO.
module edge_event_reporter
  import detector_pkg::*;
#(
  parameter int PIXEL_HEIGHT = PixelHeight,
  parameter int MIN_RUN      = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_WIDTH     = TsWidth
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [PIXEL_HEIGHT-1:0]         edge_flags,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [$clog2(PIXEL_HEIGHT)-1:0] evt_row,
  output logic                            evt_onset,
  output logic [TS_WIDTH-1:0]             evt_time,
  output logic                            overflow,
  input  logic                            clear_overflow,
  output logic [7:0]                      drop_count
);

  localparam int RW   = $clog2(PIXEL_HEIGHT);
  localparam int RUNW = $clog2(MIN_RUN + 1);
  localparam int EW   = RW + 1 + TS_WIDTH;
  localparam int DW   = $clog2(PIXEL_HEIGHT + 1);

  logic [TS_WIDTH-1:0]                     ts_q, ts_d;
  logic [PIXEL_HEIGHT-1:0]                 confirm, confirm_onset;
  logic [PIXEL_HEIGHT-1:0]                 pend_q, pend_d, pend_on_q, pend_on_d;
  logic [PIXEL_HEIGHT-1:0][TS_WIDTH-1:0]   pend_ts_q, pend_ts_d;
  logic [RW-1:0]                           sel;
  logic                                    any_pend, push, pop, full, empty;
  logic                                    push_on;
  logic [TS_WIDTH-1:0]                     push_ts;
  logic [EW-1:0]                           head;
  logic [DW-1:0]                           n_drop;
  logic [8:0]                              drop_sum;
  logic [7:0]                              drop_q, drop_d;
  logic                                    ovf_q, ovf_d;

  assign ts_d = ts_q + 1'b1;

  // Row qualifiers: one three-process FSM per row
  for (genvar i = 0; i < PIXEL_HEIGHT; i++) begin : g_row
    row_state_t      state_q, state_d;
    logic [RUNW-1:0] run_q, run_d;
    logic            f, cfm, cfm_on;

    assign f = edge_flags[i];

    // State and run counter register
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        run_q   <= '0;
      end else begin
        state_q <= state_d;
        run_q   <= run_d;
      end
    end

    // Next state: run counts consecutive samples agreeing with the candidate level
    always_comb begin
      state_d = state_q;
      run_d   = run_q;
      case (state_q)
        ST_IDLE: if (f) begin
          run_d   = RUNW'(1);
          state_d = (MIN_RUN == 1) ? ST_ACTIVE : ST_ARMING;
        end
        ST_ARMING: begin
          if (!f)                            state_d = ST_IDLE;
          else if (int'(run_q) + 1 == MIN_RUN) state_d = ST_ACTIVE;
          else                               run_d = run_q + 1'b1;
        end
        ST_ACTIVE: if (!f) begin
          run_d   = RUNW'(1);
          state_d = (MIN_RUN == 1) ? ST_IDLE : ST_RELEASING;
        end
        ST_RELEASING: begin
          if (f)                             state_d = ST_ACTIVE;
          else if (int'(run_q) + 1 == MIN_RUN) state_d = ST_IDLE;
          else                               run_d = run_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Confirm strobes: entering ACTIVE from below is an onset, falling back to IDLE from above a release
    always_comb begin
      cfm    = 1'b0;
      cfm_on = 1'b0;
      case (state_q)
        ST_IDLE, ST_ARMING:      if (state_d == ST_ACTIVE) begin cfm = 1'b1; cfm_on = 1'b1; end
        ST_ACTIVE, ST_RELEASING: if (state_d == ST_IDLE) cfm = 1'b1;
        default: ;
      endcase
    end

    assign confirm[i]       = cfm;
    assign confirm_onset[i] = cfm_on;
  end

  // Priority arbiter: lowest pending row wins; a pop this cycle frees a slot
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    push_on  = 1'b0;
    push_ts  = '0;
    for (int i = PIXEL_HEIGHT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel      = RW'(i);
        any_pend = 1'b1;
        push_on  = pend_on_q[i];
        push_ts  = pend_ts_q[i];
      end
    end
    pop  = !empty && evt_ready;
    push = any_pend && (!full || pop);
  end

  // Pending registers: grant clears, confirm (re)loads; loading over an unpushed event drops it
  always_comb begin
    pend_d    = pend_q;
    pend_on_d = pend_on_q;
    pend_ts_d = pend_ts_q;
    n_drop    = '0;
    for (int i = 0; i < PIXEL_HEIGHT; i++) begin
      if (push && (sel == RW'(i))) pend_d[i] = 1'b0;
      if (confirm[i]) begin
        if (pend_q[i] && !(push && (sel == RW'(i)))) n_drop = n_drop + DW'(1);
        pend_d[i]    = 1'b1;
        pend_on_d[i] = confirm_onset[i];
        pend_ts_d[i] = ts_q;
      end
    end
  end

  // Sticky overflow and saturating drop counter; clear takes priority over new drops
  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'(n_drop);
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clear_overflow) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (n_drop != '0) begin
      drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      ovf_d  = 1'b1;
    end
  end

  // Timestamp, pending and overflow state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q      <= '0;
      pend_q    <= '0;
      pend_on_q <= '0;
      pend_ts_q <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      pend_q    <= pend_d;
      pend_on_q <= pend_on_d;
      pend_ts_q <= pend_ts_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  edge_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .din     ({sel, push_on, push_ts}),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  assign evt_valid                      = !empty;
  assign {evt_row, evt_onset, evt_time} = head;
  assign overflow                       = ovf_q;
  assign drop_count                     = drop_q;

endmodule
